// File: rtl/sram_like_slave_mem_if.sv
// Request/response bundle between an SRAM-like master and a memory responder.
// A request transfers on a rising edge where req && addr_ok. data_ok is a one-cycle strobe with no ready; the master takes every response, in order.
interface sram_like_slave_mem_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave_mem.sv
// SRAM-like responder over a word-organised memory: pipelined accepts, in-order
// responses at a fixed latency, outstanding requests capped through addr_ok.
module sram_like_slave_mem #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                  clk,
  input logic                  rst,
  sram_like_slave_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [31:0] data;
  } stage_t;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            be;
  logic                  rst_q;
  logic [CNT_W-1:0]      count;
  logic                  accept;
  logic [31:0]           rdata_q;
  stage_t                pipe    [LATENCY];
  stage_t                pipe_in [LATENCY];

  // Upper address bits alias onto the same words.
  generate
    if (ADDR_WIDTH < 30) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];
    end
  endgenerate

  assign word_idx = bus.addr[ADDR_WIDTH+1:2];

  // A response retiring this cycle frees its slot for a same-cycle accept.
  assign bus.addr_ok = bus.req && !rst && !rst_q &&
                       ((count < CNT_MAX) || pipe[LATENCY-1].vld);
  assign accept      = bus.req && bus.addr_ok;
  assign bus.data_ok = pipe[LATENCY-1].vld;
  assign bus.rdata   = rdata_q;

  always_comb begin
    be = 4'b0000;
    case (bus.size)
      2'b00:   be = 4'b0001 << bus.addr[1:0];
      2'b01:   if (!bus.addr[0]) be = 4'b0011 << bus.addr[1:0];
      2'b10:   if (bus.addr[1:0] == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stage 0 takes a snapshot of the addressed word; it only reaches rdata for reads.
  always_comb begin
    pipe_in[0].vld  = accept;
    pipe_in[0].wr   = bus.wr;
    pipe_in[0].data = mem[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_in[i] = pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
      count   <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= pipe_in[i];
      end
      if (pipe_in[LATENCY-1].vld) begin
        rdata_q <= pipe_in[LATENCY-1].wr ? 32'h0 : pipe_in[LATENCY-1].data;
      end
      case ({accept, bus.data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Memory has no reset; illegal size/alignment leaves be at zero.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[word_idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sram_like_slave_mem.sv
// Bench for sram_like_slave_mem: three parameter points (2/2, 3/1, 4/4 latency/outstanding),
// a queue-based reference for the 2/2 instance and scenario tasks with inline checks.
module tb_sram_like_slave_mem;
  localparam int AW    = 10;
  localparam int LAT_A = 2;
  localparam int MAX_A = 2;
  localparam int LAT_B = 3;
  localparam int MAX_B = 1;
  localparam int LAT_C = 4;
  localparam int MAX_C = 4;

  logic clk;
  logic rst;

  sram_like_slave_mem_if bus_a ();
  sram_like_slave_mem_if bus_b ();
  sram_like_slave_mem_if bus_c ();

  sram_like_slave_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  sram_like_slave_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));
  sram_like_slave_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT_C), .MAX_OUTSTANDING(MAX_C)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference for instance A: word array plus queue of {due_cycle, rdata}.
  logic        mon_on     = 1'b0;
  logic        rst_last   = 1'b1;
  logic [31:0] ref_mem [1024];
  logic [63:0] exp_q[$];
  int          outst      = 0;
  logic [31:0] last_rdata = '0;
  int          acc_cyc_q[$];
  int          got_cyc_q[$];
  logic [31:0] got_q[$];
  logic        rsp_now;
  logic        exp_aok;
  logic [31:0] exp_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nbytes;
    int off;
    off = int'(a[1:0]);
    case (sz)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0 || (off % nbytes) != 0) return;
    for (int k = off; k < off + nbytes; k++) begin
      ref_mem[a[AW+1:2]][8*k +: 8] = wd[8*k +: 8];
    end
  endfunction

  // Scoreboard for instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      rsp_now = (exp_q.size() > 0) && (exp_q[0][63:32] == 32'(cyc));
      exp_aok = bus_a.req && !rst && !rst_last && ((outst < MAX_A) || rsp_now);
      exp_rd  = rsp_now ? exp_q[0][31:0] : last_rdata;
      total++;
      if (bus_a.addr_ok !== exp_aok) begin
        bad++;
        $display("FAIL sb_addr_ok cyc=%0d got=%b exp=%b", cyc, bus_a.addr_ok, exp_aok);
      end
      total++;
      if (bus_a.data_ok !== rsp_now) begin
        bad++;
        $display("FAIL sb_data_ok cyc=%0d got=%b exp=%b", cyc, bus_a.data_ok, rsp_now);
      end
      total++;
      if (bus_a.rdata !== exp_rd) begin
        bad++;
        $display("FAIL sb_rdata cyc=%0d got=%h exp=%h", cyc, bus_a.rdata, exp_rd);
      end
      if (bus_a.req && bus_a.addr_ok) acc_cyc_q.push_back(cyc);
      if (bus_a.data_ok === 1'b1) begin
        got_q.push_back(bus_a.rdata);
        got_cyc_q.push_back(cyc);
      end
      if (rsp_now) begin
        last_rdata = exp_q[0][31:0];
        void'(exp_q.pop_front());
        outst--;
      end
      if (exp_aok) begin
        if (bus_a.wr) begin
          exp_q.push_back({32'(cyc + LAT_A), 32'h0});
          ref_write(bus_a.addr, bus_a.size, bus_a.wdata);
        end else begin
          exp_q.push_back({32'(cyc + LAT_A), ref_mem[bus_a.addr[AW+1:2]]});
        end
        outst++;
      end
      if (rst) begin
        exp_q.delete();
        outst      = 0;
        last_rdata = '0;
      end
    end
    rst_last = rst;
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue_a(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    bus_a.req = 1'b1; bus_a.wr = w; bus_a.size = sz; bus_a.addr = a; bus_a.wdata = wd;
    @(negedge clk);
    while (bus_a.addr_ok !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL issue_a_timeout addr=%h waited=%0d limit=50", a, n);
    end
    @(posedge clk); #1;
    bus_a.req = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL idle_a owed=%0d required=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_cyc_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.size = 2'b10; bus_a.addr = 32'h20; bus_a.wdata = 32'h5A5A_1234;
    @(posedge clk);
    mon_on = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (bus_a.addr_ok !== 1'b0) begin bad++; $display("FAIL reset_addr_ok got=%b exp=0", bus_a.addr_ok); end
      total++;
      if (bus_a.data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok got=%b exp=0", bus_a.data_ok); end
      total++;
      if (bus_a.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus_a.rdata); end
      total++;
      if (bus_b.data_ok !== 1'b0 || bus_c.data_ok !== 1'b0) begin
        bad++; $display("FAIL reset_data_ok_bc got=%b%b exp=00", bus_b.data_ok, bus_c.data_ok);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus_a.addr_ok !== 1'b0) begin bad++; $display("FAIL release1_addr_ok got=%b exp=0", bus_a.addr_ok); end
    total++;
    if (bus_a.rdata !== 32'h0) begin bad++; $display("FAIL release1_rdata got=%h exp=0", bus_a.rdata); end
    @(negedge clk);
    total++;
    if (bus_a.addr_ok !== 1'b1) begin bad++; $display("FAIL release2_addr_ok got=%b exp=1", bus_a.addr_ok); end
    @(posedge clk); #1;
    bus_a.req = 1'b0;
    wait_idle_a();
  endtask

  task automatic test_word_rw();
    clear_logs();
    issue_a(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
    issue_a(1'b0, 2'b10, 32'h10, 32'h0);
    wait_idle_a();
    total++;
    if (got_q.size() != 2 || acc_cyc_q.size() != 2) begin
      bad++; $display("FAIL word_rw_count got=%0d exp=2", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== 32'h0) begin bad++; $display("FAIL word_rw_wr_rdata got=%h exp=0", got_q[0]); end
      total++;
      if (got_q[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word_rw_rd_rdata got=%h exp=deadbeef", got_q[1]); end
      total++;
      if (acc_cyc_q[1] - acc_cyc_q[0] != 1) begin
        bad++; $display("FAIL word_rw_b2b gap=%0d exp=1", acc_cyc_q[1] - acc_cyc_q[0]);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_cyc_q[i] - acc_cyc_q[i] != LAT_A) begin
          bad++; $display("FAIL word_rw_latency%0d got=%0d exp=%0d", i, got_cyc_q[i] - acc_cyc_q[i], LAT_A);
        end
      end
    end
  endtask

  task automatic test_subword();
    clear_logs();
    issue_a(1'b1, 2'b00, 32'h11, 32'h0000_AA00);
    issue_a(1'b1, 2'b01, 32'h12, 32'h1234_0000);
    issue_a(1'b0, 2'b10, 32'h10, 32'h0);
    wait_idle_a();
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL subword_count got=%0d exp=3", got_q.size());
    end else begin
      total++;
      if (got_q[2] !== 32'h1234_AAEF) begin bad++; $display("FAIL subword_rdata got=%h exp=1234aaef", got_q[2]); end
    end
  endtask

  task automatic test_misaligned();
    clear_logs();
    issue_a(1'b1, 2'b10, 32'h22, 32'hFFFF_FFFF);
    issue_a(1'b1, 2'b11, 32'h20, 32'hFFFF_FFFF);
    issue_a(1'b1, 2'b01, 32'h21, 32'hFFFF_FFFF);
    issue_a(1'b0, 2'b10, 32'h20, 32'h0);
    wait_idle_a();
    total++;
    if (got_q.size() != 4 || acc_cyc_q.size() != 4) begin
      bad++; $display("FAIL misaligned_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_cyc_q[i] - acc_cyc_q[i] != LAT_A) begin
          bad++; $display("FAIL misaligned_latency%0d got=%0d exp=%0d", i, got_cyc_q[i] - acc_cyc_q[i], LAT_A);
        end
      end
      total++;
      if (got_q[3] !== 32'h5A5A_1234) begin bad++; $display("FAIL misaligned_rdata got=%h exp=5a5a1234", got_q[3]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      a = $urandom();
      a[AW+1:2] = AW'(i);
      a[1:0] = 2'b00;
      issue_a(1'b1, 2'b10, a, $urandom());
    end
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      a = $urandom();
      a[AW+1:2] = AW'($urandom_range(0, 15));
      issue_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom());
    end
    wait_idle_a();
    total++;
    if (got_q.size() != 96 || acc_cyc_q.size() != 96) begin
      bad++; $display("FAIL random_count resp=%0d acc=%0d exp=96", got_q.size(), acc_cyc_q.size());
    end
  endtask

  task automatic test_backpressure();
    int   n = 0;
    int   cnt = 0;
    logic aok_exp;
    logic dok_exp;
    bus_b.req = 1'b1; bus_b.wr = 1'b1; bus_b.size = 2'b10; bus_b.addr = 32'h8; bus_b.wdata = 32'h1357_9BDF;
    @(negedge clk);
    while (bus_b.addr_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL bp_prefill_timeout waited=%0d limit=20", n); end
    @(posedge clk); #1;
    bus_b.req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus_b.req = 1'b1; bus_b.wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      aok_exp = (i == 0) || (i == 3) || (i == 6);
      dok_exp = (i == 3) || (i == 6) || (i == 9);
      total++;
      if (bus_b.addr_ok !== aok_exp) begin bad++; $display("FAIL bp_addr_ok i=%0d got=%b exp=%b", i, bus_b.addr_ok, aok_exp); end
      total++;
      if (bus_b.data_ok !== dok_exp) begin bad++; $display("FAIL bp_data_ok i=%0d got=%b exp=%b", i, bus_b.data_ok, dok_exp); end
      if (dok_exp) begin
        total++;
        if (bus_b.rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL bp_rdata i=%0d got=%h exp=13579bdf", i, bus_b.rdata); end
      end
      cnt = cnt + ((bus_b.req && bus_b.addr_ok) ? 1 : 0) - ((bus_b.data_ok === 1'b1) ? 1 : 0);
      total++;
      if (cnt > MAX_B || cnt < 0) begin bad++; $display("FAIL bp_count i=%0d got=%0d limit=%0d", i, cnt, MAX_B); end
      @(posedge clk); #1;
      if (i == 6) bus_b.req = 1'b0;
    end
  endtask

  task automatic prefill_c(input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    bus_c.req = 1'b1; bus_c.wr = 1'b1; bus_c.size = 2'b10; bus_c.addr = a; bus_c.wdata = wd;
    @(negedge clk);
    while (bus_c.addr_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL c_prefill_timeout addr=%h waited=%0d limit=20", a, n); end
    @(posedge clk); #1;
    bus_c.req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        aok_exp;
    logic        dok_exp;
    logic [31:0] rd_exp;
    prefill_c(32'h40, 32'h0BAD_F00D);
    prefill_c(32'h44, 32'h600D_CAFE);
    repeat (8) @(posedge clk);
    #1;
    bus_c.req = 1'b1; bus_c.wr = 1'b0; bus_c.addr = 32'h40;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      aok_exp = (i < 6);
      dok_exp = (i >= LAT_C) && (i < LAT_C + 6);
      rd_exp  = ((i - LAT_C) % 2 == 1) ? 32'h600D_CAFE : 32'h0BAD_F00D;
      total++;
      if (bus_c.addr_ok !== aok_exp) begin bad++; $display("FAIL b2b_addr_ok i=%0d got=%b exp=%b", i, bus_c.addr_ok, aok_exp); end
      total++;
      if (bus_c.data_ok !== dok_exp) begin bad++; $display("FAIL b2b_data_ok i=%0d got=%b exp=%b", i, bus_c.data_ok, dok_exp); end
      if (dok_exp) begin
        total++;
        if (bus_c.rdata !== rd_exp) begin bad++; $display("FAIL b2b_rdata i=%0d got=%h exp=%h", i, bus_c.rdata, rd_exp); end
      end
      @(posedge clk); #1;
      bus_c.addr = (i % 2 == 0) ? 32'h44 : 32'h40;
      if (i == 5) bus_c.req = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    bus_c.req = 1'b1; bus_c.wr = 1'b0; bus_c.addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 2) begin
        total++;
        if (bus_c.addr_ok !== 1'b1) begin bad++; $display("FAIL mid_addr_ok i=%0d got=%b exp=1", i, bus_c.addr_ok); end
      end
      total++;
      if (bus_c.data_ok !== 1'b0) begin bad++; $display("FAIL mid_data_ok i=%0d got=%b exp=0", i, bus_c.data_ok); end
      if (i == 3) begin
        total++;
        if (bus_c.rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata_cleared got=%h exp=0", bus_c.rdata); end
      end
      @(posedge clk); #1;
      if (i == 1) begin bus_c.req = 1'b0; rst = 1'b1; end
      if (i == 2) rst = 1'b0;
    end
    bus_c.req = 1'b1; bus_c.addr = 32'h44;
    @(negedge clk);
    while (bus_c.addr_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL mid_reread_timeout waited=%0d limit=20", n); end
    @(posedge clk); #1;
    bus_c.req = 1'b0;
    n = 1;
    @(negedge clk);
    while (bus_c.data_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != LAT_C) begin bad++; $display("FAIL mid_reread_latency got=%0d exp=%0d", n, LAT_C); end
    total++;
    if (bus_c.rdata !== 32'h600D_CAFE) begin bad++; $display("FAIL mid_reread_rdata got=%h exp=600dcafe", bus_c.rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = 2'b10; bus_b.addr = '0; bus_b.wdata = '0;
    bus_c.req = 1'b0; bus_c.wr = 1'b0; bus_c.size = 2'b10; bus_c.addr = '0; bus_c.wdata = '0;
    test_reset();
    test_word_rw();
    test_subword();
    test_misaligned();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    wait_idle_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
